red_pitaya_fads_gate: RTL and testbench
=======================================

# red_pitaya_fads_gate

Parametrised droplet detector and sort-trigger generator for the FADS path. It runs in the ADC clock domain between the fast-ADC input and the ASG trigger mux. It replaces the single-threshold comparator with:
- a hysteresis detector,
- per-droplet width and peak measurement,
- width/peak qualification,
- a programmable sort delay,
- a fixed-length trigger pulse, with droplet and sort counters for readout.

## Interface
Parameters:
- DW, 14, ADC sample width; samples and thresholds are two's-complement signed.
- CW, 24, width of width/delay/pulse counters.
- NW, 32, width of event counters.

Ports:
- adc_clk_i  in  1  ADC clock; sole clock.
- adc_rstn_i  in  1  reset, synchronous, active-low.
- adc_a_i  in  DW  fluorescence sample, signed.
- enable_i  in  1  block enable.
- cfg_thr_high_i  in  DW  droplet-start threshold, signed.
- cfg_thr_low_i  in  DW  droplet-end threshold, signed.
- cfg_wmin_i  in  CW  minimum accepted width in cycles, inclusive.
- cfg_wmax_i  in  CW  maximum accepted width in cycles, inclusive.
- cfg_peak_min_i  in  DW  minimum accepted peak, signed.
- cfg_delay_i  in  CW  cycles from decision to trigger rise.
- cfg_pulse_i  in  CW  trigger high time in cycles.
- sort_trig_o  out  1  sort trigger to ASG.
- busy_o  out  1  high in any state except IDLE.
- event_o  out  1  one-cycle strobe at each droplet end.
- event_sort_o  out  1  decision for the current event_o; valid only with event_o.
- last_width_o  out  CW  width of the last finished droplet.
- last_peak_o  out  DW  peak of the last finished droplet.
- droplet_cnt_o  out  NW  count of finished droplets.
- sort_cnt_o  out  NW  count of accepted droplets.

## Operation
- adc_a_i is registered once into s. All comparisons use s and are signed.
- Reset (adc_rstn_i low at a clock edge): state IDLE, all outputs 0, all counters 0.
- IDLE:
  - if enable_i and s > cfg_thr_high_i: go to DROPLET, set width to 1 and peak to s.
- DROPLET:
  - each cycle with s >= cfg_thr_low_i: width increments (saturating at 2^CW-1) and peak becomes max(peak, s).
  - first cycle with s < cfg_thr_low_i (that sample is excluded): decide.
    - accept = (cfg_wmin_i <= width <= cfg_wmax_i) and (peak >= cfg_peak_min_i).
    - latch last_width_o, last_peak_o, cfg_delay_i and cfg_pulse_i.
    - pulse event_o with event_sort_o = accept.
    - increment droplet_cnt_o; if accepted, increment sort_cnt_o.
    - go to DELAY if accepted, otherwise IDLE.
- DELAY: count the latched delay, then go to FIRE. A latched delay of 0 goes to FIRE on the next cycle.
- FIRE:
  - sort_trig_o is high for max(latched pulse, 1) cycles.
  - then go to REARM.
- REARM: wait until s < cfg_thr_low_i, then go to IDLE. A droplet that is still bright cannot retrigger.
- Dead time: samples arriving during DELAY, FIRE or REARM are not measured or counted.
- enable_i low:
  - the next clock forces IDLE and drops sort_trig_o.
  - a droplet in progress is discarded with no event_o and no counter change.
  - counters and last_* values hold.
- Counters wrap modulo 2^NW.
- cfg_thr_low_i > cfg_thr_high_i is legal. A droplet then ends on its first sample that is below cfg_thr_low_i.
- cfg_wmin_i > cfg_wmax_i is legal and rejects every droplet.

## Timing
- Input register adds 1 cycle. Sample k on adc_a_i is s at cycle k+1.
- Start of a droplet: first sample k above threshold puts the block in DROPLET at cycle k+2.
- End of a droplet: first low sample j produces event_o and the counter update at cycle j+2.
- Trigger rise: sort_trig_o rises at cycle j+3+D, where D is the latched delay. It stays high for exactly P cycles (P = max(latched pulse, 1)).
- sort_trig_o and all outputs are registered; there are no combinational paths from inputs to outputs.
- cfg_* inputs other than delay/pulse are used live each cycle. Software changes them only while busy_o is low.

## Configuration
- FADS_PEAK_EN defined:
  - peak tracking is implemented.
  - last_peak_o is valid.
  - the peak criterion is part of accept.
- FADS_PEAK_EN undefined:
  - no peak logic is implemented.
  - last_peak_o is tied to 0.
  - cfg_peak_min_i is ignored, so accept depends on width only.

## Test plan
- Reset during FIRE: adc_rstn_i low for 1 cycle -> next cycle sort_trig_o = 0, busy_o = 0, counters = 0.
- Accepted droplet, with thr_high = 1000, thr_low = 800, wmin = 5, wmax = 20, peak_min = 1500, delay = 10, pulse = 4:
  - stimulus: 10 samples at 2000, then 0.
  - response: event_o with event_sort_o = 1, last_width_o = 10, last_peak_o = 2000.
  - response: sort_trig_o rises 13 cycles after the first low sample and stays high 4 cycles; sort_cnt_o = 1.
- Rejection, same configuration:
  - stimulus: a 3-sample droplet, then a 30-sample droplet, then a 10-sample droplet at 1200.
  - response: three events, all with event_sort_o = 0; droplet_cnt_o = 3, sort_cnt_o = 0, sort_trig_o never high.
  - with FADS_PEAK_EN undefined, the 1200 droplet is accepted instead.
- Hysteresis and rearm:
  - stimulus: a signal falling 2000 -> 900 -> 2000 -> 0. Response: one droplet only, width counted through the 900 sample.
  - stimulus: a signal still above thr_low after FIRE. Response: no new droplet until it drops below 800.
- Boundaries:
  - delay = 0, pulse = 0: trigger rises 3 cycles after the first low sample and is high for 1 cycle.
  - enable_i dropped mid-droplet: no event, counters unchanged.

Source files
------------

// File: rtl/red_pitaya_fads_gate.sv
// FADS droplet detector: hysteresis gate, width/peak qualification, delayed sort trigger.
// Define FADS_PEAK_EN to build peak tracking and the peak acceptance criterion.
module red_pitaya_fads_gate #(
    parameter int DW = 14,
    parameter int CW = 24,
    parameter int NW = 32
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic signed [DW-1:0] adc_a_i,
    input  logic                 enable_i,
    input  logic signed [DW-1:0] cfg_thr_high_i,
    input  logic signed [DW-1:0] cfg_thr_low_i,
    input  logic        [CW-1:0] cfg_wmin_i,
    input  logic        [CW-1:0] cfg_wmax_i,
    input  logic signed [DW-1:0] cfg_peak_min_i,
    input  logic        [CW-1:0] cfg_delay_i,
    input  logic        [CW-1:0] cfg_pulse_i,
    output logic                 sort_trig_o,
    output logic                 busy_o,
    output logic                 event_o,
    output logic                 event_sort_o,
    output logic        [CW-1:0] last_width_o,
    output logic signed [DW-1:0] last_peak_o,
    output logic        [NW-1:0] droplet_cnt_o,
    output logic        [NW-1:0] sort_cnt_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DROPLET = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_FIRE    = 3'd3;
    localparam logic [2:0] S_REARM   = 3'd4;

    logic        [2:0]    state;
    logic signed [DW-1:0] s;
    logic        [CW-1:0] width;
    logic        [CW-1:0] cnt;
    logic        [CW-1:0] pul_lat;
    logic                 w_ok;
    logic                 p_ok;
    logic                 accept;

`ifdef FADS_PEAK_EN
    logic signed [DW-1:0] peak;
    assign p_ok = (peak >= cfg_peak_min_i);
`else
    logic unused_peak_min;
    assign unused_peak_min = ^cfg_peak_min_i;
    assign p_ok            = 1'b1;
    assign last_peak_o     = '0;
`endif

    assign w_ok   = (width >= cfg_wmin_i) && (width <= cfg_wmax_i);
    assign accept = w_ok && p_ok;
    assign busy_o = (state != S_IDLE);

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            s             <= '0;
            state         <= S_IDLE;
            width         <= '0;
            cnt           <= '0;
            pul_lat       <= '0;
            sort_trig_o   <= 1'b0;
            event_o       <= 1'b0;
            event_sort_o  <= 1'b0;
            last_width_o  <= '0;
            droplet_cnt_o <= '0;
            sort_cnt_o    <= '0;
`ifdef FADS_PEAK_EN
            peak          <= '0;
            last_peak_o   <= '0;
`endif
        end else begin
            s            <= adc_a_i;
            event_o      <= 1'b0;
            event_sort_o <= 1'b0;
            // Disable wins over every state; an unfinished droplet is simply dropped.
            if (!enable_i) begin
                state       <= S_IDLE;
                sort_trig_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (s > cfg_thr_high_i) begin
                            state <= S_DROPLET;
                            width <= CW'(1);
`ifdef FADS_PEAK_EN
                            peak  <= s;
`endif
                        end
                    end
                    S_DROPLET: begin
                        if (s >= cfg_thr_low_i) begin
                            if (width != '1) width <= width + 1'b1;
`ifdef FADS_PEAK_EN
                            if (s > peak) peak <= s;
`endif
                        end else begin
                            last_width_o  <= width;
`ifdef FADS_PEAK_EN
                            last_peak_o   <= peak;
`endif
                            cnt           <= cfg_delay_i;
                            pul_lat       <= (cfg_pulse_i == '0) ? CW'(1) : cfg_pulse_i;
                            event_o       <= 1'b1;
                            event_sort_o  <= accept;
                            droplet_cnt_o <= droplet_cnt_o + 1'b1;
                            if (accept) begin
                                sort_cnt_o <= sort_cnt_o + 1'b1;
                                state      <= S_DELAY;
                            end else begin
                                state      <= S_IDLE;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (cnt == '0) begin
                            state       <= S_FIRE;
                            sort_trig_o <= 1'b1;
                            cnt         <= pul_lat - 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_FIRE: begin
                        if (cnt == '0) begin
                            state       <= S_REARM;
                            sort_trig_o <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_REARM: begin
                        // Hold off until the sorted droplet has left the detector.
                        if (s < cfg_thr_low_i) state <= S_IDLE;
                    end
                    default: begin
                        state       <= S_IDLE;
                        sort_trig_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_fads_gate.sv
// Bench for red_pitaya_fads_gate: droplet vector table plus event/trigger scoreboards.
module tb_red_pitaya_fads_gate;

    localparam int DW = 14;
    localparam int CW = 24;
    localparam int NW = 32;

    logic clk = 1'b0;
    logic rstn, en;
    logic signed [DW-1:0] adc, thr_hi, thr_lo, pk_min;
    logic        [CW-1:0] wmin, wmax, dly, pls;
    logic trig, busy, ev, ev_sort;
    logic        [CW-1:0] lw;
    logic signed [DW-1:0] lp;
    logic        [NW-1:0] dcnt, scnt;

    always #5 clk = ~clk;

    red_pitaya_fads_gate #(.DW(DW), .CW(CW), .NW(NW)) dut (
        .adc_clk_i      (clk),
        .adc_rstn_i     (rstn),
        .adc_a_i        (adc),
        .enable_i       (en),
        .cfg_thr_high_i (thr_hi),
        .cfg_thr_low_i  (thr_lo),
        .cfg_wmin_i     (wmin),
        .cfg_wmax_i     (wmax),
        .cfg_peak_min_i (pk_min),
        .cfg_delay_i    (dly),
        .cfg_pulse_i    (pls),
        .sort_trig_o    (trig),
        .busy_o         (busy),
        .event_o        (ev),
        .event_sort_o   (ev_sort),
        .last_width_o   (lw),
        .last_peak_o    (lp),
        .droplet_cnt_o  (dcnt),
        .sort_cnt_o     (scnt)
    );

    typedef struct { int cyc; int w; int pk; bit srt; } ev_t;
    typedef struct { int rise; int len; } tr_t;
    typedef struct { int amp; int len; int d; int p; bit acc_pk; bit acc_nopk; } vec_t;

    ev_t evq[$];
    tr_t tq[$];
    int  nvec = 0, nerr = 0, cyc = 0;
    int  mdl_drop = 0, mdl_sort = 0, mdl_lw = 0;
    bit  trig_chk_en = 1'b1, trig_prev = 1'b0, in_pulse = 1'b0;
    int  hi_cnt = 0, want_len = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Runs once per cycle at the falling edge, away from the sampling edge.
    task automatic monitor();
        ev_t e;
        tr_t t;
        if (ev) begin
            if (evq.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL event_unexpected: got event_o=1, want none (cycle %0d)", cyc);
            end else begin
                e = evq.pop_front();
                mdl_drop++;
                if (e.srt) mdl_sort++;
                mdl_lw = e.w;
                chk("event_cycle", cyc, e.cyc);
                chk("event_sort", ev_sort, e.srt);
                chk("last_width", lw, e.w);
                chk("last_peak", lp, e.pk);
                chk("droplet_cnt", dcnt, mdl_drop);
                chk("sort_cnt", scnt, mdl_sort);
            end
        end
        if (trig_chk_en) begin
            if (trig && !trig_prev) begin
                if (tq.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL trig_unexpected: got sort_trig_o=1, want 0 (cycle %0d)", cyc);
                end else begin
                    t = tq.pop_front();
                    chk("trig_rise", cyc, t.rise);
                    want_len = t.len;
                    in_pulse = 1'b1;
                end
                hi_cnt = 0;
            end
            if (trig) hi_cnt++;
            if (!trig && trig_prev && in_pulse) begin
                chk("trig_len", hi_cnt, want_len);
                in_pulse = 1'b0;
            end
        end
        trig_prev = trig;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input int v);
        step();
        adc = DW'(v);
    endtask

    // j is the index of the first low sample that closes the droplet.
    task automatic expect_drop(input int j, input int w, input int amp, input bit acc,
                               input int d, input int p, input bit with_trig);
        ev_t e;
        tr_t t;
        e.cyc = j + 2;
        e.w   = w;
        e.srt = acc;
`ifdef FADS_PEAK_EN
        e.pk  = amp;
`else
        e.pk  = 0;
`endif
        evq.push_back(e);
        if (acc && with_trig) begin
            t.rise = j + 3 + d;
            t.len  = (p == 0) ? 1 : p;
            tq.push_back(t);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit acc;
`ifdef FADS_PEAK_EN
        acc = v.acc_pk;
`else
        acc = v.acc_nopk;
`endif
        dly = CW'(v.d);
        pls = CW'(v.p);
        for (int i = 0; i < v.len; i++) drive(v.amp);
        drive(0);
        expect_drop(cyc, v.len, v.amp, acc, v.d, v.p, 1'b1);
        repeat (40) drive(0);
    endtask

    initial begin
        vec_t vt[12];
        vt[0]  = '{2000, 10, 10, 4, 1'b1, 1'b1};
        vt[1]  = '{2000,  3, 10, 4, 1'b0, 1'b0};
        vt[2]  = '{2000, 30, 10, 4, 1'b0, 1'b0};
        vt[3]  = '{1200, 10, 10, 4, 1'b0, 1'b1};
        vt[4]  = '{2000,  5,  3, 2, 1'b1, 1'b1};
        vt[5]  = '{2000, 20,  3, 2, 1'b1, 1'b1};
        vt[6]  = '{2000,  4,  3, 2, 1'b0, 1'b0};
        vt[7]  = '{2000, 21,  3, 2, 1'b0, 1'b0};
        vt[8]  = '{2000,  6,  0, 0, 1'b1, 1'b1};
        vt[9]  = '{1500,  8,  1, 3, 1'b1, 1'b1};
        vt[10] = '{1499,  8,  1, 3, 1'b0, 1'b1};
        vt[11] = '{1001,  7,  2, 1, 1'b0, 1'b1};

        rstn = 1'b0; en = 1'b1; adc = '0;
        thr_hi = 14'sd1000; thr_lo = 14'sd800; pk_min = 14'sd1500;
        wmin = 24'd5; wmax = 24'd20; dly = 24'd10; pls = 24'd4;
        repeat (3) step();
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_event", ev, 0);
        chk("rst_last_width", lw, 0);
        chk("rst_last_peak", lp, 0);
        chk("rst_droplet_cnt", dcnt, 0);
        chk("rst_sort_cnt", scnt, 0);
        rstn = 1'b1;
        repeat (3) drive(0);

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // Dip to 900 stays inside the hysteresis band and is counted.
        dly = 24'd2; pls = 24'd2;
        drive(2000); drive(2000); drive(900); drive(2000); drive(2000);
        drive(0);
        expect_drop(cyc, 5, 2000, 1'b1, 2, 2, 1'b1);
        repeat (40) drive(0);

        // Droplet stays bright through delay and fire: no second event.
        dly = 24'd0; pls = 24'd1;
        repeat (6) drive(2000);
        drive(0);
        expect_drop(cyc, 6, 2000, 1'b1, 0, 1, 1'b1);
        repeat (15) drive(2000);
        repeat (40) drive(0);
        chk("rearm_droplet_cnt", dcnt, mdl_drop);
        chk("rearm_busy", busy, 0);

        // Enable dropped mid-droplet.
        dly = 24'd3; pls = 24'd2;
        repeat (4) drive(2000);
        chk("en_busy_mid", busy, 1);
        en = 1'b0;
        drive(2000); drive(2000); drive(0); drive(0);
        en = 1'b1;
        repeat (10) drive(0);
        chk("en_busy", busy, 0);
        chk("en_droplet_cnt", dcnt, mdl_drop);
        chk("en_sort_cnt", scnt, mdl_sort);
        chk("en_last_width", lw, mdl_lw);

        // Reset while the trigger is high.
        trig_chk_en = 1'b0;
        dly = 24'd0; pls = 24'd20;
        repeat (6) drive(2000);
        drive(0);
        expect_drop(cyc, 6, 2000, 1'b1, 0, 20, 1'b0);
        repeat (5) drive(0);
        chk("fire_trig_high", trig, 1);
        rstn = 1'b0;
        step();
        chk("fire_rst_trig", trig, 0);
        chk("fire_rst_busy", busy, 0);
        chk("fire_rst_droplet_cnt", dcnt, 0);
        chk("fire_rst_sort_cnt", scnt, 0);
        rstn = 1'b1;
        repeat (5) step();

        chk("evq_drained", evq.size(), 0);
        chk("tq_drained", tq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
